msu_vol_ramp: RTL and testbench

MSU_VOL_RAMP -- requirements
Module: msu_vol_ramp

---
 rtl/msu_vol_ramp_pkg.sv | 19 +
 rtl/msu_vol_mul.sv | 18 +
 rtl/msu_vol_ramp.sv | 119 +++++++++++
 tb/tb_msu_vol_ramp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msu_vol_ramp_pkg.sv
// rtl/msu_vol_ramp_pkg.sv - shared MSU volume widths, unity-gain constant and gain mapping
package msu_vol_ramp_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 9;
    localparam int VOL_W    = 8;

    localparam logic [VOL_W-1:0]  VOL_MAX    = 8'hFF;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]   gain_t;

    // Full-scale volume maps to exact unity so 255 passes samples through untouched.
    function automatic gain_t vol_to_gain(input logic [VOL_W-1:0] vol);
        return (vol == VOL_MAX) ? GAIN_UNITY : {1'b0, vol};
    endfunction

endpackage

// File: rtl/msu_vol_mul.sv
// rtl/msu_vol_mul.sv - one-channel signed sample by unsigned gain scaler, floor shift by 8
module msu_vol_mul
    import msu_vol_ramp_pkg::*;
(
    input  sample_t sample,
    input  gain_t   gain,
    output sample_t scaled
);

    logic signed [SAMPLE_W+GAIN_W:0] product;
    logic                            unused_bits;

    // Gain is zero-extended so the multiply stays signed; >>8 on the slice floors toward -inf.
    assign product     = $signed(sample) * $signed({1'b0, gain});
    assign scaled      = product[SAMPLE_W+7:8];
    assign unused_bits = ^{product[SAMPLE_W+GAIN_W:SAMPLE_W+8], product[7:0]};

endmodule

// File: rtl/msu_vol_ramp.sv
// rtl/msu_vol_ramp.sv - MSU volume ramp with latch sync and two-stage scaling pipeline
module msu_vol_ramp
    import msu_vol_ramp_pkg::*;
#(
    parameter int RAMP_DIV = 4
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic [7:0]  volume_in,
    input  logic        volume_latch,
    input  logic [1:0]  audio_ctrl,
    input  logic        in_valid,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    input  logic        out_ready,
    output logic [7:0]  vol_cur_out
);

    localparam logic [7:0] STEP_LAST = 8'(RAMP_DIV - 1);

    logic [1:0]  latch_sr;
    logic [7:0]  vol_tgt;
    logic [7:0]  vol_cur;
    logic [7:0]  vol_eff;
    logic [7:0]  step_cnt;
    logic        accept;
    logic        s2_free;
    logic        s1_valid;
    sample_t     s1_l;
    sample_t     s1_r;
    gain_t       s1_gain;
    sample_t     mul_l;
    sample_t     mul_r;
    logic        unused_ctrl;

    assign vol_eff     = audio_ctrl[0] ? vol_tgt : 8'd0;
    assign s2_free     = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_free;
    assign accept      = in_valid && in_ready;
    assign vol_cur_out = vol_cur;
    assign unused_ctrl = audio_ctrl[1];

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            latch_sr <= 2'b00;
            vol_tgt  <= 8'd0;
        end else begin
            latch_sr <= {latch_sr[0], volume_latch};
            if (latch_sr == 2'b01)
                vol_tgt <= volume_in;
        end
    end

    // The step compares against the registered target, so a same-cycle load only affects later steps.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= 8'd0;
            vol_cur  <= 8'd0;
        end else if (accept) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= 8'd0;
                if (vol_cur < vol_eff)
                    vol_cur <= vol_cur + 8'd1;
                else if (vol_cur > vol_eff)
                    vol_cur <= vol_cur - 8'd1;
            end else begin
                step_cnt <= step_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_l     <= '0;
            s1_r     <= '0;
            s1_gain  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_l     <= in_l;
            s1_r     <= in_r;
            s1_gain  <= vol_to_gain(vol_cur);
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    msu_vol_mul u_mul_l (
        .sample (s1_l),
        .gain   (s1_gain),
        .scaled (mul_l)
    );

    msu_vol_mul u_mul_r (
        .sample (s1_r),
        .gain   (s1_gain),
        .scaled (mul_r)
    );

    // Data only updates when S1 has something, so a held or drained output keeps its last value.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_l <= mul_l;
                out_r <= mul_r;
            end
        end
    end

endmodule

// File: tb/tb_msu_vol_ramp.sv
// tb/tb_msu_vol_ramp.sv - self-checking bench for msu_vol_ramp
module tb_msu_vol_ramp;

    localparam int RAMP_DIV = 4;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  volume_in = 8'd0;
    logic        volume_latch = 1'b0;
    logic [1:0]  audio_ctrl = 2'b00;
    logic        in_valid = 1'b0;
    logic [15:0] in_l = 16'd0;
    logic [15:0] in_r = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_ready = 1'b1;
    logic [7:0]  vol_cur_out;

    int total = 0;
    int bad = 0;

    int          m_vol = 0;
    int          m_tgt = 0;
    int          m_acc = 0;
    logic        m_h1 = 1'b0;
    logic        m_h2 = 1'b0;
    logic [31:0] exp_q[$];
    int          n_out = 0;
    logic [31:0] last_out = 32'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_out = 32'd0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;
    vec_t tbl[5];

    msu_vol_ramp #(.RAMP_DIV(RAMP_DIV)) dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .volume_in    (volume_in),
        .volume_latch (volume_latch),
        .audio_ctrl   (audio_ctrl),
        .in_valid     (in_valid),
        .in_l         (in_l),
        .in_r         (in_r),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_l        (out_l),
        .out_r        (out_r),
        .out_ready    (out_ready),
        .vol_cur_out  (vol_cur_out)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int scale(input logic [15:0] s, input int g);
        int p;
        p = int'($signed(s)) * g;
        if (p >= 0)
            return p / 256;
        return -((-p + 255) / 256);
    endfunction

    // Reference model: accepts, ramp and target sampled between edges.
    initial begin
        int g;
        int eff;
        forever begin
            @(negedge clkin);
            if (!rst_n) begin
                m_vol = 0; m_tgt = 0; m_acc = 0;
                m_h1 = 1'b0; m_h2 = 1'b0; prev_stall = 1'b0;
                exp_q.delete();
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_vol_cur", 32'(vol_cur_out), 32'd0);
            end else begin
                check("vol_cur", 32'(vol_cur_out), 32'(m_vol));
                if (out_ready)
                    check("in_ready_free", 32'(in_ready), 32'd1);
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", {out_l, out_r}, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_output: got %h expected none", {out_l, out_r});
                    end else begin
                        check("out_data", {out_l, out_r}, exp_q.pop_front());
                        n_out++;
                        last_out = {out_l, out_r};
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_l, out_r};
                if (in_valid && in_ready) begin
                    g = (m_vol == 255) ? 256 : m_vol;
                    exp_q.push_back({16'(scale(in_l, g)), 16'(scale(in_r, g))});
                    m_acc++;
                    if (m_acc % RAMP_DIV == 0) begin
                        eff = audio_ctrl[0] ? m_tgt : 0;
                        if (m_vol < eff) m_vol++;
                        else if (m_vol > eff) m_vol--;
                    end
                end
                if (!m_h2 && m_h1)
                    m_tgt = int'(volume_in);
                m_h2 = m_h1;
                m_h1 = volume_latch;
            end
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        ok = 1'b0;
        in_l = l; in_r = r; in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clkin);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clkin); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++)
            send(16'($urandom), 16'($urandom));
    endtask

    task automatic pad_phase();
        send_rand((RAMP_DIV - m_acc % RAMP_DIV) % RAMP_DIV);
    endtask

    task automatic latch(input logic [7:0] v);
        volume_in = v;
        volume_latch = 1'b1;
        @(posedge clkin); #1;
        volume_latch = 1'b0;
        repeat (2) begin @(posedge clkin); #1; end
    endtask

    task automatic check_vol(input string name, input int exp);
        @(negedge clkin);
        check(name, 32'(vol_cur_out), 32'(exp));
        @(posedge clkin); #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clkin); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        total++; bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n0;
        int sent;
        bit acc;
        tbl[0] = '{16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF};
        tbl[1] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[2] = '{16'h0100, 16'hFF00, 16'h0080, 16'hFF80};
        tbl[3] = '{16'h1234, 16'hEDCC, 16'h091A, 16'hF6E6};
        tbl[4] = '{16'h0003, 16'hFFFD, 16'h0001, 16'hFFFE};

        repeat (3) @(posedge clkin);
        #1 rst_n = 1'b1;
        @(negedge clkin);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_vol", 32'(vol_cur_out), 32'd0);
        check("reset_out", {out_l, out_r}, 32'd0);
        @(posedge clkin); #1;

        // Ramp 0 -> 255 takes exactly 1020 accepts at RAMP_DIV=4.
        audio_ctrl = 2'b11;
        latch(8'hFF);
        repeat (1019) send(16'h4000, 16'h4000);
        check_vol("ramp_1019", 254);
        send(16'h4000, 16'h4000);
        check_vol("ramp_1020", 255);
        send(16'h4000, 16'h4000);
        drain();
        check("ramp_unity_out", last_out, 32'h40004000);

        // Random stall pattern with incrementing samples at unity gain.
        n0 = n_out;
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            in_l = 16'(sent);
            in_r = ~16'(sent);
            @(negedge clkin);
            acc = in_valid && in_ready;
            @(posedge clkin); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        drain();
        check("stall_count", 32'(n_out - n0), 32'd1000);
        check("stall_last", last_out, {16'd999, ~16'd999});

        // Stop: ramp back down to silence.
        pad_phase();
        audio_ctrl = 2'b00;
        send_rand(3);
        check_vol("down_3", 255);
        send_rand(1);
        check_vol("down_4", 254);
        send_rand(1016);
        check_vol("down_1020", 0);
        send(16'h7FFF, 16'h8000);
        drain();
        check("down_silent_out", last_out, 32'd0);

        // Half gain table.
        audio_ctrl = 2'b01;
        latch(8'd128);
        send_rand(512);
        check_vol("half_vol", 128);
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].l, tbl[i].r);
            @(negedge clkin);
            check("tbl_lat1_valid", 32'(out_valid), 32'd0);
            @(negedge clkin);
            check("tbl_lat2_valid", 32'(out_valid), 32'd1);
            check("tbl_data", {out_l, out_r}, {tbl[i].el, tbl[i].er});
            @(posedge clkin); #1;
        end

        // Target load coinciding with a step uses the old target for that step.
        latch(8'd20);
        send_rand(432);
        pad_phase();
        check_vol("coinc_start", 20);
        send(16'd1, 16'd1);
        send(16'd2, 16'd2);
        volume_in = 8'd10;
        volume_latch = 1'b1;
        send(16'd3, 16'd3);
        volume_latch = 1'b0;
        send(16'd4, 16'd4);
        check_vol("coinc_old_tgt", 20);
        send_rand(40);
        check_vol("coinc_desc", 10);
        send_rand(8);
        check_vol("coinc_hold", 10);

        // Reset with two samples in flight.
        drain();
        send(16'h1111, 16'h2222);
        send(16'h3333, 16'h4444);
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("inflight_rst_valid", 32'(out_valid), 32'd0);
        check("inflight_rst_vol", 32'(vol_cur_out), 32'd0);
        repeat (2) @(posedge clkin);
        #1 rst_n = 1'b1;
        n0 = n_out;
        repeat (5) begin @(posedge clkin); #1; end
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        send(16'h1234, 16'h4321);
        drain();
        check("post_rst_count", 32'(n_out - n0), 32'd1);
        check("post_rst_out", last_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
